fetch_stage: RTL and testbench



---
 rtl/femto_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 51 +++++
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/femto_pkg.sv
// Shared femtoRV32 definitions: datapath width, the NOP encoding used on
// reset and flush, the PC increment and the fetch FSM state encoding.
package femto_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle around the fetch stage: PC register, instruction memory,
// execute redirect and the IF/ID output towards decode.
interface fetch_stage_if;
  import femto_pkg::*;

  logic [XLEN-1:0] pc_cur;
  logic            pc_load;
  logic [XLEN-1:0] pc_next;

  // Valid/ready handshakes: a transfer happens on a cycle where valid and
  // ready are both high; valid never waits on ready. imem responses carry
  // no ready because the fetch stage always has room for them.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  logic [1:0]      state_dbg;

  modport master (
    input  pc_cur,
    output pc_load, pc_next,
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_instr,
    input  if_ready,
    output state_dbg
  );

  modport slave (
    output pc_cur,
    input  pc_load, pc_next,
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_instr,
    output if_ready,
    input  state_dbg
  );

endinterface

// File: rtl/if_id_reg.sv
// One-entry IF/ID register. Flush beats a write, a write beats a consume,
// so a consume and a new response in the same cycle keeps valid high.
module if_id_reg
  import femto_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_instr,
  input  logic            consume,
  input  logic            flush,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (wr) begin
      valid <= 1'b1;
      pc    <= wr_pc;
      instr <= wr_instr;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// femtoRV32 instruction fetch: one outstanding imem request, PC advance on
// acceptance, redirect flush with drop of the in-flight response.
module fetch_stage
  import femto_pkg::*;
(
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DROP  = DROP;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [XLEN-1:0] req_pc;
  logic            redirect;
  logic            slot_free;
  logic            req_fire;
  logic            rsp_wr;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  assign redirect  = bus.redirect_valid && !rst;
  assign slot_free = !out_valid || bus.if_ready;
  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_wr    = (state == S_WAIT) && bus.imem_rsp_valid && !redirect;

  // Issuing only into a free slot is what lets responses never stall.
  assign bus.imem_req_valid = !rst && (state == S_ISSUE) && slot_free && !bus.redirect_valid;
  assign bus.imem_addr      = rst ? '0 : bus.pc_cur;

  always_comb begin
    bus.pc_load = redirect || req_fire;
    bus.pc_next = '0;
    if (redirect) begin
      bus.pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (!rst) begin
      bus.pc_next = bus.pc_cur + PC_STEP;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ISSUE: begin
        if (req_fire) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) state_nxt = S_ISSUE;
        else if (redirect)      state_nxt = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_ISSUE;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) req_pc <= bus.pc_cur;
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .wr       (rsp_wr),
    .wr_pc    (req_pc),
    .wr_instr (bus.imem_rsp_data),
    .consume  (bus.if_ready),
    .flush    (redirect),
    .valid    (out_valid),
    .pc       (out_pc),
    .instr    (out_instr)
  );

  assign bus.if_valid  = out_valid;
  assign bus.if_pc     = out_pc;
  assign bus.if_instr  = out_instr;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench-side PC register and imem model,
// expected queues filled by the stimulus, popped by a negedge monitor.
module tb_fetch_stage;
  import femto_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] exp_addr_q[$];
  logic [XLEN-1:0] exp_pcn_q[$];
  logic [XLEN-1:0] exp_pc_q[$];
  logic [XLEN-1:0] exp_instr_q[$];
  int fire_cyc_q[$];
  int rise_cyc_q[$];

  int              fires = 0;
  int              cyc = 0;
  int              mem_k = 1;
  logic [XLEN-1:0] pc_rst_val = '0;
  logic            fire_s = 1'b0;
  logic            load_s = 1'b0;
  logic [XLEN-1:0] addr_s = '0;
  logic [XLEN-1:0] next_s = '0;
  logic            pend = 1'b0;
  int              pend_cnt = 0;
  logic [XLEN-1:0] pend_addr = '0;
  logic            prev_valid = 1'b0;

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return {a[15:0], 16'hA013};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Environment: PC register and instruction memory with latency mem_k
  always @(negedge clk) begin
    fire_s = bus.imem_req_valid && bus.imem_req_ready;
    addr_s = bus.imem_addr;
    load_s = bus.pc_load;
    next_s = bus.pc_next;
  end

  always @(posedge clk) begin
    #1;
    bus.imem_rsp_valid = 1'b0;
    if (rst) begin
      pend       = 1'b0;
      bus.pc_cur = pc_rst_val;
    end else begin
      if (load_s) bus.pc_cur = next_s;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(pend_addr);
          pend               = 1'b0;
        end
      end
      if (fire_s) begin
        if (mem_k == 1) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(addr_s);
        end else begin
          pend      = 1'b1;
          pend_cnt  = mem_k - 1;
          pend_addr = addr_s;
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        fires++;
        fire_cyc_q.push_back(cyc);
        if (exp_addr_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL req_addr: unexpected request to %h", bus.imem_addr);
        end else check("req_addr", bus.imem_addr, exp_addr_q.pop_front());
      end
      if (bus.pc_load) begin
        if (exp_pcn_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL pc_next: unexpected pc_load with %h", bus.pc_next);
        end else check("pc_next", bus.pc_next, exp_pcn_q.pop_front());
      end
      if (bus.if_valid && !prev_valid) rise_cyc_q.push_back(cyc);
      if (bus.if_valid && bus.if_ready) begin
        if (exp_pc_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL if_out: unexpected output pc %h instr %h", bus.if_pc, bus.if_instr);
        end else begin
          check("if_pc", bus.if_pc, exp_pc_q.pop_front());
          check("if_instr", bus.if_instr, exp_instr_q.pop_front());
        end
      end
    end
    prev_valid = bus.if_valid;
  end

  task automatic push_out(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(instr);
  endtask

  task automatic hold_reset(input logic [XLEN-1:0] pc0, input int k);
    @(posedge clk); #1;
    rst                = 1'b1;
    pc_rst_val         = pc0;
    bus.pc_cur         = pc0;
    mem_k              = k;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    fires = 0;
    fire_cyc_q.delete();
    rise_cyc_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_fires(input int n);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (fires >= n) return;
    end
    fail_now("wait_fires timeout");
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_pc_q.size() == 0 && exp_addr_q.size() == 0 && exp_pcn_q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_out_left"}, 32'(exp_pc_q.size()), 32'd0);
    check({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_pcn_left"}, 32'(exp_pcn_q.size()), 32'd0);
  endtask

  initial begin
    rst                = 1'b1;
    bus.pc_cur         = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;

    // 1: reset values, then sequential fetch 0,4,8 at k=1
    hold_reset(32'h0, 1);
    @(negedge clk);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_instr", bus.if_instr, NOP_INSTR);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_pc_load", 32'(bus.pc_load), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(ISSUE));
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_pcn_q  = '{32'h4, 32'h8, 32'hC};
    push_out(32'h0, 32'h0000_A013);
    push_out(32'h4, 32'h0004_A013);
    push_out(32'h8, 32'h0008_A013);
    @(posedge clk); #1;
    release_reset();
    wait_fires(3);
    bus.imem_req_ready = 1'b0;
    drain("seq");
    if (fire_cyc_q.size() < 3 || rise_cyc_q.size() < 1) fail_now("timing_log short");
    else begin
      check("fire_gap1", 32'(fire_cyc_q[1] - fire_cyc_q[0]), 32'd2);
      check("fire_gap2", 32'(fire_cyc_q[2] - fire_cyc_q[1]), 32'd2);
      check("latency", 32'(rise_cyc_q[0] - fire_cyc_q[0]), 32'd2);
    end

    // 2: decode stall holds the entry and freezes the PC
    bus.if_ready = 1'b0;
    hold_reset(32'h40, 2);
    exp_addr_q.push_back(32'h40);
    exp_pcn_q.push_back(32'h44);
    release_reset();
    repeat (8) @(posedge clk);
    #1;
    check("stall_if_valid", 32'(bus.if_valid), 32'd1);
    check("stall_if_pc", bus.if_pc, 32'h40);
    check("stall_if_instr", bus.if_instr, 32'h0040_A013);
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("stall_pc_cur", bus.pc_cur, 32'h44);
    check("stall_fires", 32'(fires), 32'd1);
    push_out(32'h40, 32'h0040_A013);
    push_out(32'h44, 32'h0044_A013);
    exp_addr_q.push_back(32'h44);
    exp_pcn_q.push_back(32'h48);
    bus.if_ready = 1'b1;
    wait_fires(2);
    bus.imem_req_ready = 1'b0;
    drain("stall");

    // 3: redirect to 0x103 while waiting; the 0x80 response is dropped
    hold_reset(32'h80, 3);
    exp_addr_q.push_back(32'h80);
    exp_pcn_q.push_back(32'h84);
    release_reset();
    wait_fires(1);
    exp_pcn_q.push_back(32'h100);
    exp_addr_q.push_back(32'h100);
    exp_pcn_q.push_back(32'h104);
    push_out(32'h100, 32'h0100_A013);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    @(negedge clk);
    check("redir_state_wait", 32'(bus.state_dbg), 32'(WAIT));
    check("redir_no_req", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    check("redir_state_drop", 32'(bus.state_dbg), 32'(DROP));
    check("redir_if_valid", 32'(bus.if_valid), 32'd0);
    wait_fires(2);
    bus.imem_req_ready = 1'b0;
    drain("redir");

    // 4: redirect in the same cycle as the response
    hold_reset(32'hC0, 2);
    exp_addr_q.push_back(32'hC0);
    exp_pcn_q.push_back(32'hC4);
    release_reset();
    wait_fires(1);
    @(posedge clk); #1;
    exp_pcn_q.push_back(32'h200);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    bus.imem_req_ready = 1'b0;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    check("coin_state", 32'(bus.state_dbg), 32'(ISSUE));
    check("coin_if_valid", 32'(bus.if_valid), 32'd0);
    check("coin_if_instr", bus.if_instr, NOP_INSTR);
    drain("coin");

    // 5: PC wraps from 0xFFFF_FFFC to 0
    hold_reset(32'hFFFF_FFFC, 1);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_pcn_q.push_back(32'h0);
    push_out(32'hFFFF_FFFC, 32'hFFFC_A013);
    release_reset();
    wait_fires(1);
    bus.imem_req_ready = 1'b0;
    drain("wrap");
    check("wrap_pc_cur", bus.pc_cur, 32'h0);

    // 6: asynchronous reset in WAIT, restart from the reset PC 0x400
    hold_reset(32'h300, 4);
    exp_addr_q.push_back(32'h300);
    exp_pcn_q.push_back(32'h304);
    release_reset();
    wait_fires(1);
    rst        = 1'b1;
    pc_rst_val = 32'h400;
    bus.pc_cur = 32'h400;
    #1;
    check("arst_state", 32'(bus.state_dbg), 32'(ISSUE));
    check("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("arst_pc_load", 32'(bus.pc_load), 32'd0);
    check("arst_pc_next", bus.pc_next, 32'h0);
    check("arst_imem_addr", bus.imem_addr, 32'h0);
    check("arst_if_valid", 32'(bus.if_valid), 32'd0);
    mem_k = 1;
    exp_addr_q.push_back(32'h400);
    exp_pcn_q.push_back(32'h404);
    push_out(32'h400, 32'h0400_A013);
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    wait_fires(1);
    bus.imem_req_ready = 1'b0;
    drain("arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
